// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional 2-entry skid buffer, flush and stall counter
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int SKID = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  logic acc, con;
  assign acc = in_valid && in_ready;
  assign con = out_valid && out_ready;
  always_ff @(posedge clk)
    if (reset) stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  if (SKID == 0) begin : g_reg
    logic v;
    logic [WIDTH-1:0] d;
    always_ff @(posedge clk)
      if (reset) begin
        v <= 1'b0;
        d <= RESET_VAL;
      end else begin
        if (acc && !flush) d <= in_data;
        v <= !flush && (acc || (v && !con));
      end
    assign in_ready = !v || out_ready;
    assign out_valid = v;
    assign out_data = d;
  end else begin : g_skid
    state_t state, nxt;
    logic rdy;
    logic [WIDTH-1:0] main, skid;
    always_comb
      nxt = flush ? EMPTY :
            state == EMPTY ? (acc ? ONE : EMPTY) :
            state == ONE ? ((acc && !con) ? FULL : (!acc && con) ? EMPTY : ONE) :
            (con ? ONE : FULL);
    always_ff @(posedge clk)
      if (reset) begin
        state <= EMPTY;
        rdy <= 1'b1;
        main <= RESET_VAL;
        skid <= '0;
      end else begin
        state <= nxt;
        rdy <= nxt != FULL;
        if (!flush && acc && (state == EMPTY || con)) main <= in_data;
        else if (!flush && state == FULL && con) main <= skid;
        if (!flush && state == ONE && acc && !con) skid <= in_data;
      end
    assign in_ready = rdy;
    assign out_valid = state != EMPTY;
    assign out_data = main;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives three pipe_stage_reg variants with shared directed stimulus against a FIFO model
module tb_pipe_stage_reg;
  localparam logic [7:0] RV = 8'h5A;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic [2:0] ir, ov;
  logic [7:0] od [3];
  logic [15:0] sc0, sc1;
  logic [2:0] sc2;
  logic [15:0] sc [3];
  int checks = 0, errors = 0;
  bit en = 0;
  int cap [3] = '{1, 2, 2};
  int mx [3] = '{65535, 65535, 7};
  int n [3] = '{0, 0, 0};
  int mc [3] = '{0, 0, 0};
  bit known [3] = '{1, 1, 1};
  logic [7:0] mb [3][2];
  always #5 clk = ~clk;
  pipe_stage_reg #(.WIDTH(8), .SKID(0), .RESET_VAL(RV), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .stall_cnt(sc0));
  pipe_stage_reg #(.WIDTH(8), .SKID(1), .RESET_VAL(RV), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .stall_cnt(sc1));
  pipe_stage_reg #(.WIDTH(8), .SKID(1), .RESET_VAL(RV), .CNT_W(3)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .stall_cnt(sc2));
  assign sc[0] = sc0;
  assign sc[1] = sc1;
  assign sc[2] = {13'b0, sc2};
  function automatic bit m_rdy(int i);
    return cap[i] == 1 ? (n[i] == 0 || out_ready) : (n[i] < 2);
  endfunction
  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got %h want %h", nm, i, $time, act, exp);
    end
  endtask
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      bit a, c;
      a = in_valid && m_rdy(i);
      c = n[i] > 0 && out_ready;
      if (reset) begin
        n[i] = 0;
        mc[i] = 0;
        known[i] = 1;
      end else begin
        if (n[i] > 0 && !out_ready && mc[i] < mx[i]) mc[i]++;
        if (flush) begin
          n[i] = 0;
          known[i] = 0;
        end else begin
          if (c) begin
            mb[i][0] = mb[i][1];
            n[i]--;
          end
          if (a) begin
            mb[i][n[i]] = in_data;
            n[i]++;
            known[i] = 0;
          end
        end
      end
    end
  always @(negedge clk)
    if (en)
      for (int i = 0; i < 3; i++) begin
        chk("in_ready", i, 32'(ir[i]), 32'(m_rdy(i)));
        chk("out_valid", i, 32'(ov[i]), 32'(n[i] > 0));
        chk("stall_cnt", i, 32'(sc[i]), 32'(mc[i]));
        if (n[i] > 0) chk("out_data", i, 32'(od[i]), 32'(mb[i][0]));
        else if (known[i]) chk("out_data_rst", i, 32'(od[i]), 32'(RV));
      end
  task automatic cyc(bit r, bit f, bit v, logic [7:0] d, bit o);
    reset = r;
    flush = f;
    in_valid = v;
    in_data = d;
    out_ready = o;
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0);
    en = 1;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("L_rst_valid", i, 32'(ov[i]), 0);
      chk("L_rst_data", i, 32'(od[i]), 32'h5A);
      chk("L_rst_ready", i, 32'(ir[i]), 1);
    end
    cyc(0, 0, 1, 8'h11, 1);
    chk("L_s1", 0, 32'(od[0]), 32'h11);
    cyc(0, 0, 1, 8'h22, 1);
    cyc(0, 0, 1, 8'h33, 1);
    chk("L_s3", 1, 32'(od[1]), 32'h33);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 8'hAA, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 8'hBB, 0);
    chk("L_stall4", 0, 32'(sc[0]), 4);
    chk("L_hold", 0, 32'(od[0]), 32'hAA);
    chk("L_noready", 0, 32'(ir[0]), 0);
    chk("L_full", 1, 32'(ir[1]), 0);
    cyc(0, 0, 1, 8'hBB, 1);
    chk("L_nobubble", 0, 32'(od[0]), 32'hBB);
    chk("L_skidpop", 1, 32'(od[1]), 32'hBB);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 8'h01, 0);
    cyc(0, 0, 1, 8'h02, 0);
    chk("L_full2", 1, 32'(ir[1]), 0);
    chk("L_first", 1, 32'(od[1]), 32'h01);
    cyc(0, 0, 0, 0, 1);
    chk("L_second", 1, 32'(od[1]), 32'h02);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 8'h77, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0);
    chk("L_sat", 2, 32'(sc[2]), 7);
    cyc(0, 0, 1, 8'h88, 0);
    cyc(0, 1, 1, 8'h99, 0);
    chk("L_flush_valid", 1, 32'(ov[1]), 0);
    chk("L_flush_ready", 1, 32'(ir[1]), 1);
    chk("L_flush_cnt", 2, 32'(sc[2]), 7);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'hC1, 0);
    cyc(0, 0, 1, 8'hC2, 0);
    chk("L_full3", 1, 32'(ir[1]), 0);
    cyc(1, 0, 1, 8'hC3, 1);
    for (int i = 0; i < 3; i++) begin
      chk("L_mrst_valid", i, 32'(ov[i]), 0);
      chk("L_mrst_data", i, 32'(od[i]), 32'h5A);
      chk("L_mrst_cnt", i, 32'(sc[i]), 0);
    end
    cyc(0, 0, 1, 8'hD1, 1);
    chk("L_resume", 1, 32'(od[1]), 32'hD1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
